// File: rtl/slurmboy_pkg.sv
// rtl/slurmboy_pkg.sv - shared types and constants for the slurmboy memory arbiter
package slurmboy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_AUX = 1'b1;

endpackage

// File: rtl/slurmboy_rr_arb2.sv
// rtl/slurmboy_rr_arb2.sv - combinational two-way round-robin pick
module slurmboy_rr_arb2
  import slurmboy_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // On a tie the master that was not served last goes next.
  always_comb begin
    grant = MST_CPU;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = MST_AUX;
    end
  end

endmodule

// File: rtl/slurmboy_mem_arbiter.sv
// rtl/slurmboy_mem_arbiter.sv - two-master round-robin arbiter in front of the single-port RAM
module slurmboy_mem_arbiter
  import slurmboy_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              pick;
  logic              resp;

  // Byte-lane and out-of-range address bits are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  slurmboy_rr_arb2 u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d      = ACCESS;
          grant_d      = pick;
          last_grant_d = pick;
          ram_en_d     = 1'b1;
          ram_we_d     = pick ? m1_wstrb : m0_wstrb;
          ram_addr_d   = pick ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
          ram_wdata_d  = pick ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        state_d  = RESP;
        ram_en_d = 1'b0;
        ram_we_d = 4'b0000;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= MST_CPU;
      last_grant_q <= MST_AUX;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0000;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // The RAM's registered read data lines up with the RESP cycle.
  assign resp     = (state_q == RESP);
  assign m0_ready = resp && (grant_q == MST_CPU);
  assign m1_ready = resp && (grant_q == MST_AUX);
  assign m0_rdata = m0_ready ? ram_rdata : 32'h0;
  assign m1_rdata = m1_ready ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_slurmboy_mem_arbiter.sv
// tb/tb_slurmboy_mem_arbiter.sv - scoreboard bench for slurmboy_mem_arbiter
module tb_slurmboy_mem_arbiter;

  localparam int ADDR_W = 12;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              m0_valid, m1_valid;
  logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]        m0_wstrb, m1_wstrb;
  logic              m0_ready, m1_ready;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  slurmboy_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM with one-cycle synchronous read and byte writes
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic m, input logic chk, input logic [31:0] data);
    exp_t e;
    e.m = m; e.chk = chk; e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every ready pulse is matched against the next expected response
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (m0_ready || m1_ready)) begin
      check("ready_exclusive", {31'b0, m0_ready & m1_ready}, 32'h0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: ready m0=%0d m1=%0d with no response expected", m0_ready, m1_ready);
      end else begin
        e = sb_q.pop_front();
        check("sb_master", {31'b0, m1_ready}, {31'b0, e.m});
        if (e.chk) check("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
        check("sb_other_rdata", m1_ready ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  task automatic raise(input logic m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    if (m == 1'b0) begin
      m0_addr = a; m0_wdata = wd; m0_wstrb = s; m0_valid = 1'b1;
    end else begin
      m1_addr = a; m1_wdata = wd; m1_wstrb = s; m1_valid = 1'b1;
    end
  endtask

  task automatic drop(input logic m);
    if (m == 1'b0) m0_valid = 1'b0;
    else           m1_valid = 1'b0;
  endtask

  // Counts falling edges until the master's ready is seen
  task automatic wait_ready(input logic m, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge CLK);
      if ((m == 1'b0) ? m0_ready : m1_ready) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_ready m%0d: no ready within %0d cycles", m, max);
    end
  endtask

  // Raised just after a rising edge: latency in cycles is edges seen minus one
  task automatic txn(input logic m, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output int lat);
    int n;
    raise(m, a, wd, s);
    wait_ready(m, 20, n);
    lat = n - 1;
    @(posedge CLK);
    #1;
    drop(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, n;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    mem[6] = 32'hCAFEF00D;
    mem[8] = 32'h12345678;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_ram_en", {31'b0, ram_en}, 32'h0);
    check("rst_ram_we", {28'b0, ram_we}, 32'h0);
    check("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_readys", {30'b0, m1_ready, m0_ready}, 32'h0);
    RST = 1'b0;

    // Tie from reset, then strict alternation over 8 transactions
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 1'b1, 32'hDEADBEEF);
      push(1'b1, 1'b1, 32'hCAFEF00D);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          txn(1'b0, 32'h14, 32'h0, 4'h0, lat);
          if (k == 0) check("tie_m0_latency", lat, 32'd2);
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          txn(1'b1, 32'h18, 32'h0, 4'h0, lat);
          if (k == 0) check("tie_m1_latency", lat, 32'd5);
        end
      end
    join

    // Single read with command timing
    push(1'b0, 1'b1, 32'hDEADBEEF);
    raise(1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge CLK);
    check("rd_idle_en", {31'b0, ram_en}, 32'h0);
    @(negedge CLK);
    check("rd_access_en", {31'b0, ram_en}, 32'h1);
    check("rd_access_addr", {20'b0, ram_addr}, 32'd5);
    check("rd_access_we", {28'b0, ram_we}, 32'h0);
    @(negedge CLK);
    check("rd_resp_m0_ready", {31'b0, m0_ready}, 32'h1);
    check("rd_resp_m1_ready", {31'b0, m1_ready}, 32'h0);
    check("rd_resp_en", {31'b0, ram_en}, 32'h0);
    @(posedge CLK);
    #1;
    drop(1'b0);

    // Byte write from m1, read back through m0
    push(1'b1, 1'b0, 32'h0);
    raise(1'b1, 32'h20, 32'h000000AA, 4'b0001);
    @(negedge CLK);
    @(negedge CLK);
    check("wr_access_en", {31'b0, ram_en}, 32'h1);
    check("wr_access_we", {28'b0, ram_we}, 32'h1);
    check("wr_access_addr", {20'b0, ram_addr}, 32'd8);
    check("wr_access_wdata", ram_wdata, 32'h000000AA);
    @(negedge CLK);
    check("wr_resp_m1_ready", {31'b0, m1_ready}, 32'h1);
    @(posedge CLK);
    #1;
    drop(1'b1);
    push(1'b0, 1'b1, 32'h123456AA);
    txn(1'b0, 32'h20, 32'h0, 4'h0, lat);
    check("wr_readback_latency", lat, 32'd2);

    // Alias: 2^(ADDR_W+2) + 4 lands on word 1
    push(1'b0, 1'b0, 32'h0);
    txn(1'b0, 32'h0000_4004, 32'h11223344, 4'hF, lat);
    push(1'b0, 1'b1, 32'h11223344);
    txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat);

    // Reset during ACCESS drops the transaction
    raise(1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
    check("rstmid_pre_en", {31'b0, ram_en}, 32'h1);
    RST = 1'b1;
    #1;
    check("rstmid_ram_en", {31'b0, ram_en}, 32'h0);
    check("rstmid_ram_we", {28'b0, ram_we}, 32'h0);
    check("rstmid_ram_addr", {20'b0, ram_addr}, 32'h0);
    check("rstmid_ram_wdata", ram_wdata, 32'h0);
    check("rstmid_readys", {30'b0, m1_ready, m0_ready}, 32'h0);
    check("rstmid_rdata", m0_rdata | m1_rdata, 32'h0);
    drop(1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    push(1'b0, 1'b1, 32'hDEADBEEF);
    txn(1'b0, 32'h14, 32'h0, 4'h0, lat);
    check("rstmid_reissue_latency", lat, 32'd2);

    // Late request from m1 while m0 is in ACCESS
    push(1'b0, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b1, 32'hCAFEF00D);
    fork
      begin
        txn(1'b0, 32'h14, 32'h0, 4'h0, lat0);
      end
      begin
        @(negedge CLK);
        @(negedge CLK);
        check("late_m0_access_addr", {20'b0, ram_addr}, 32'd5);
        raise(1'b1, 32'h18, 32'h0, 4'h0);
        @(negedge CLK);
        check("late_m1_not_at_m0_resp", {31'b0, m1_ready}, 32'h0);
        @(negedge CLK);
        check("late_idle_en", {31'b0, ram_en}, 32'h0);
        check("late_idle_m1_ready", {31'b0, m1_ready}, 32'h0);
        wait_ready(1'b1, 10, n);
        lat1 = n;
        @(posedge CLK);
        #1;
        drop(1'b1);
      end
    join
    check("late_m0_latency", lat0, 32'd2);
    check("late_m1_idle_plus", lat1, 32'd2);

    repeat (3) @(negedge CLK);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slurmboy_mem_arbiter.md
# slurmboy_mem_arbiter

Two-master arbiter sharing the single-port on-chip RAM between the picorv32 native memory interface (master 0) and a secondary bus master such as the boot loader or DMA (master 1). It sits between the CPU and the RAM inside slurmboy_top and performs one complete read or write transaction at a time, with round-robin fairness. Both master ports use the picorv32 valid/ready handshake. The RAM has a one-cycle synchronous read.

## Interface
Parameters:
- ADDR_W, 12: RAM word-address width. The RAM holds 2^ADDR_W 32-bit words.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- m0_valid / m1_valid  in  1  request; held high until the matching ready
- m0_addr / m1_addr  in  32  byte address; bits [ADDR_W+1:2] are used
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 means read
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables
- ram_addr  out  ADDR_W  word address
- ram_wdata  out  32  write data to the RAM
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any valid is high, pick a winner and go to ACCESS. Register grant, ram_addr, ram_we = winner wstrb, ram_wdata, ram_en = 1.
- **Arbitration:**
  - Single requester wins outright.
  - Both requesting: the master not granted last wins.
  - last_grant resets to 1, so master 0 (the CPU) wins the first tie.
  - last_grant updates on entry to ACCESS.
- **ACCESS:** the RAM sees the command this cycle. Next state is RESP; ram_en and ram_we clear on that transition.
- **RESP:**
  - Assert ready for the granted master only.
  - Its rdata = ram_rdata. Reads return RAM data; writes return whatever the RAM drives, which the master ignores.
  - The non-granted master's ready = 0 and rdata = 0.
  - Next state is always IDLE.
- Upper address bits above ADDR_W+1 and bits [1:0] are ignored; addresses alias modulo the RAM size.
- A grant is locked for the whole transaction. A new request arriving after the grant waits for the next IDLE.
- If a master drops valid before its ready, the transaction still completes and the ready pulse is issued regardless. This is a protocol violation by the master; the arbiter does not detect it.
- **Reset (RST high, asynchronous):**
  - State = IDLE, last_grant = 1.
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - Both ready = 0, both rdata = 0.
  - An in-flight transaction is dropped with no ready issued; the master must reissue it after reset.

## Timing
- Cycle N: in IDLE with valid high.
- Cycle N+1: ACCESS, with ram_en high.
- Cycle N+2: RESP, with ready high. Latency from valid to ready is 2 cycles.
- Cycle N+3: back in IDLE; earliest sampling of the next request.
- Throughput: one transaction per 3 cycles.
- Two masters both continuously requesting alternate grants: 0, 1, 0, 1, …
- ready is never high for both masters in the same cycle, and never high for more than one consecutive cycle per transaction.
- ram_en is high for exactly one cycle per transaction.
- ram_* outputs are registered. mN_ready and mN_rdata are combinational from state, grant and ram_rdata.

## Structure
- Shared package slurmboy_pkg:
  - arb_state_t enum (IDLE, ACCESS, RESP)
  - master index constants MST_CPU = 0, MST_AUX = 1
- Sub-module slurmboy_rr_arb2: combinational two-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Output: grant index.
- The FSM, command registers and response mux live in slurmboy_mem_arbiter.

## Test plan
- Single read:
  - Preload word 5 = 0xDEADBEEF.
  - m0 reads addr 0x14.
  - Expect ram_en for one cycle at N+1 with ram_addr 5 and ram_we 0; m0_ready and m0_rdata = 0xDEADBEEF at N+2; m1_ready stays 0.
- Byte write:
  - m1 writes addr 0x20, wdata 0x000000AA, wstrb 0001.
  - Expect ram_we 0001 and ram_addr 8.
  - A subsequent m0 read of 0x20 returns bits [7:0] = 0xAA, with the other bytes unchanged.
- Tie from reset:
  - Both masters assert valid in the same first cycle after reset.
  - Expect m0 served first (ready at N+2), then m1 (ready at N+5).
  - With continuous requests, grants alternate strictly for 8 transactions.
- Alias:
  - m0 writes 0x11223344 to addr (2^(ADDR_W+2)) + 0x4.
  - A read of addr 0x4 returns 0x11223344.
- Reset mid-transaction:
  - Assert RST during ACCESS.
  - Expect all outputs 0 immediately, with no ready pulse.
  - After release, a re-issued request completes normally with 2-cycle latency.
- Late request:
  - m1 raises valid while m0 is in ACCESS.
  - m1 is not granted until the next IDLE.
  - m1_ready arrives at the IDLE cycle + 2.
